fifo_route_buf: RTL and testbench

FIFO_ROUTE_BUF -- requirements
Module: fifo_route_buf

---
 rtl/fifo_tool_pkg.sv | 19 +
 rtl/fifo_ring.sv | 72 +++++++
 rtl/fifo_route_buf.sv | 154 +++++++++++++++
 tb/tb_fifo_route_buf.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_tool_pkg.sv
// Shared definitions for the routing FIFO.
// Holds the router FSM state encoding, the saturation limit for the
// discard counter, and a helper that sizes the channel-select field.
package fifo_tool_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } route_state_t;

  localparam logic [31:0] DROP_CNT_MAX = 32'hFFFF_FFFF;

  // Width of a channel index; a single channel still gets a 1-bit field.
  function automatic int sel_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/fifo_ring.sv
// Circular word buffer used by fifo_route_buf.
// Ports:
//   clk, srst        - clock and synchronous active-high reset
//   push, wr_data    - write a word (ignored when full)
//   pop              - drop the head word (ignored when empty)
//   rd_data          - current head word (valid while !empty)
//   count            - occupancy, 0..DEPTH
//   full, empty      - occupancy flags
module fifo_ring #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W:0]        count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset; stale entries are never visible because the
  // read pointer only advances over written words.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is read combinationally so a word pushed at one edge can leave
  // on the very next cycle.
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/fifo_route_buf.sv
// Buffered 1-to-N stream router.
// Input words are queued in a small ring and forwarded to the active
// output channel. A channel change first drains the queue to the old
// channel, then spends one SWITCH cycle before accepting new input.
// Ports:
//   ap_clk, ap_rst                     - clock, synchronous active-high reset
//   fifo_i_din/full_n/write            - input stream handshake
//   fifo_o_din/full_n/write            - N_OUT output streams, packed per channel
//   fifo_en                            - 1 routes input words, 0 discards them
//   sel, sel_load                      - channel change request
//   cur_sel                            - active channel
//   sel_err                            - one-cycle pulse on a rejected request
//   drop_cnt                           - saturating count of discarded words
module fifo_route_buf
  import fifo_tool_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_OUT      = 4,
  parameter int DEPTH      = 4
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [DATA_WIDTH-1:0]         fifo_i_din,
  output logic                          fifo_i_full_n,
  input  logic                          fifo_i_write,
  output logic [N_OUT*DATA_WIDTH-1:0]   fifo_o_din,
  input  logic [N_OUT-1:0]              fifo_o_full_n,
  output logic [N_OUT-1:0]              fifo_o_write,
  input  logic                          fifo_en,
  input  logic [sel_width(N_OUT)-1:0]   sel,
  input  logic                          sel_load,
  output logic [sel_width(N_OUT)-1:0]   cur_sel,
  output logic                          sel_err,
  output logic [31:0]                   drop_cnt
);

  localparam int SEL_W = sel_width(N_OUT);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [SEL_W:0] N_OUT_EXT = (SEL_W+1)'(N_OUT);

  route_state_t          state_reg, state_next;
  logic [SEL_W-1:0]      cur_sel_reg, cur_sel_next;
  logic [SEL_W-1:0]      pend_sel_reg, pend_sel_next;
  logic                  sel_err_reg, sel_err_next;
  logic [31:0]           drop_cnt_reg, drop_cnt_next;

  logic                  ring_push;
  logic                  ring_pop;
  logic [DATA_WIDTH-1:0] ring_head;
  logic [CNT_W-1:0]      ring_count;
  logic                  ring_full;
  logic                  ring_empty;
  logic                  sel_bad;
  logic                  send_ok;

  fifo_ring #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ring (
    .clk     (ap_clk),
    .srst    (ap_rst),
    .push    (ring_push),
    .pop     (ring_pop),
    .wr_data (fifo_i_din),
    .rd_data (ring_head),
    .count   (ring_count),
    .full    (ring_full),
    .empty   (ring_empty)
  );

  // Compare one bit wider so out-of-range codes are visible when N_OUT
  // is not a power of two.
  assign sel_bad   = ({1'b0, sel} >= N_OUT_EXT);
  assign ring_push = fifo_i_write && fifo_en && fifo_i_full_n;
  assign ring_pop  = |fifo_o_write;

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg    <= RUN;
      cur_sel_reg  <= '0;
      pend_sel_reg <= '0;
      sel_err_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cur_sel_reg  <= cur_sel_next;
      pend_sel_reg <= pend_sel_next;
      sel_err_reg  <= sel_err_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next    = state_reg;
    cur_sel_next  = cur_sel_reg;
    pend_sel_next = pend_sel_reg;
    sel_err_next  = 1'b0;
    case (state_reg)
      RUN: begin
        if (sel_load) begin
          if (sel_bad) begin
            sel_err_next = 1'b1;
          end else if (sel != cur_sel_reg) begin
            pend_sel_next = sel;
            state_next    = DRAIN;
          end
        end
      end
      DRAIN: begin
        sel_err_next = sel_load;
        if (ring_count == '0) begin
          state_next = SWITCH;
        end
      end
      SWITCH: begin
        sel_err_next = sel_load;
        cur_sel_next = pend_sel_reg;
        state_next   = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (fifo_i_write && !fifo_en && (drop_cnt_reg != DROP_CNT_MAX)) begin
      drop_cnt_next = drop_cnt_reg + 32'd1;
    end
  end

  // Output logic. New input is only taken in RUN, so nothing queued
  // before a switch can reach the new channel.
  always_comb begin
    fifo_i_full_n = 1'b1;
    if (fifo_en) begin
      fifo_i_full_n = !ap_rst && (state_reg == RUN) && !ring_full;
    end
    send_ok = !ap_rst && (state_reg != SWITCH) && !ring_empty;
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
    logic chan_hit;
    assign chan_hit = send_ok && (cur_sel_reg == SEL_W'(gi));
    assign fifo_o_write[gi] = chan_hit && fifo_o_full_n[gi];
    assign fifo_o_din[gi*DATA_WIDTH +: DATA_WIDTH] = chan_hit ? ring_head : '0;
  end

  assign cur_sel  = cur_sel_reg;
  assign sel_err  = sel_err_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_fifo_route_buf.sv
module tb_fifo_route_buf;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  din;
  logic         full_n_o;
  logic         wr;
  logic [127:0] o_din;
  logic [3:0]   o_full_n;
  logic [3:0]   o_write;
  logic         en;
  logic [1:0]   sel;
  logic         sel_load;
  logic [1:0]   cur_sel;
  logic         sel_err;
  logic [31:0]  drop;

  // Five-channel instance: with four channels a 2-bit select cannot
  // carry an out-of-range code, so range rejection is exercised here.
  logic [31:0]  din5;
  logic         full_n5;
  logic         wr5;
  logic [159:0] o_din5;
  logic [4:0]   o_full_n5;
  logic [4:0]   o_write5;
  logic [2:0]   sel5;
  logic         sel_load5;
  logic [2:0]   cur_sel5;
  logic         sel_err5;
  logic [31:0]  drop5;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  fifo_route_buf #(.DATA_WIDTH(32), .N_OUT(4), .DEPTH(4)) u_dut (
    .ap_clk(clk), .ap_rst(rst),
    .fifo_i_din(din), .fifo_i_full_n(full_n_o), .fifo_i_write(wr),
    .fifo_o_din(o_din), .fifo_o_full_n(o_full_n), .fifo_o_write(o_write),
    .fifo_en(en), .sel(sel), .sel_load(sel_load),
    .cur_sel(cur_sel), .sel_err(sel_err), .drop_cnt(drop)
  );

  fifo_route_buf #(.DATA_WIDTH(32), .N_OUT(5), .DEPTH(4)) u_dut5 (
    .ap_clk(clk), .ap_rst(rst),
    .fifo_i_din(din5), .fifo_i_full_n(full_n5), .fifo_i_write(wr5),
    .fifo_o_din(o_din5), .fifo_o_full_n(o_full_n5), .fifo_o_write(o_write5),
    .fifo_en(en), .sel(sel5), .sel_load(sel_load5),
    .cur_sel(cur_sel5), .sel_err(sel_err5), .drop_cnt(drop5)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; wr = 1'b0; din = '0; o_full_n = 4'hF;
    sel = '0; sel_load = 1'b0;
    din5 = '0; wr5 = 1'b0; o_full_n5 = 5'h1F; sel5 = '0; sel_load5 = 1'b0;

    // Reset state, with reset still asserted
    cyc();
    #1;
    check("rst_full_n", 160'(full_n_o), 160'(0));
    check("rst_o_write", 160'(o_write), 160'(0));
    check("rst_cur_sel", 160'(cur_sel), 160'(0));
    check("rst_sel_err", 160'(sel_err), 160'(0));
    check("rst_drop_cnt", 160'(drop), 160'(0));
    rst = 1'b0;
    cyc();

    // Pass-through: words 1..8 back to back onto channel 0
    for (int j = 0; j <= 9; j++) begin
      if (j < 8) begin
        wr = 1'b1; din = 32'(j + 1);
      end else begin
        wr = 1'b0;
      end
      #1;
      if (j == 0 || j == 9) begin
        check("pt_idle", 160'(o_write), 160'(0));
      end else begin
        check("pt_write", 160'(o_write), 160'(4'b0001));
        check("pt_data", 160'(o_din), 160'(j));
      end
      check("pt_in_ready", 160'(full_n_o), 160'(1));
      cyc();
    end

    // Backpressure: channel 0 blocked while five words are offered
    o_full_n = 4'hE;
    for (int k = 0; k < 4; k++) begin
      wr = 1'b1; din = 32'(11 + k);
      #1;
      check("bp_accept", 160'(full_n_o), 160'(1));
      check("bp_hold", 160'(o_write), 160'(0));
      cyc();
    end
    din = 32'd15;
    #1;
    check("bp_full", 160'(full_n_o), 160'(0));
    cyc();
    #1;
    check("bp_full_hold", 160'(full_n_o), 160'(0));
    o_full_n = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_write", 160'(o_write), 160'(4'b0001));
      check("bp_data", 160'(o_din), 160'(11 + k));
      if (k < 2) check("bp_in_ready", 160'(full_n_o), 160'(k));
      cyc();
      if (k == 1) wr = 1'b0;
    end
    #1;
    check("bp_empty", 160'(o_write), 160'(0));
    cyc();

    // Switch to channel 2 with three words queued
    o_full_n = 4'hE;
    for (int k = 0; k < 3; k++) begin
      wr = 1'b1; din = 32'(21 + k);
      cyc();
    end
    wr = 1'b0; sel = 2'd2; sel_load = 1'b1;
    #1;
    check("sw_run_ready", 160'(full_n_o), 160'(1));
    cyc();
    sel_load = 1'b0; o_full_n = 4'hF; wr = 1'b1; din = 32'd99;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("sw_drain_ready", 160'(full_n_o), 160'(0));
      check("sw_drain_write", 160'(o_write), 160'(4'b0001));
      check("sw_drain_data", 160'(o_din), 160'(21 + k));
      check("sw_drain_sel", 160'(cur_sel), 160'(0));
      cyc();
    end
    #1;
    check("sw_drain_idle", 160'(o_write), 160'(0));
    check("sw_drain_idle_ready", 160'(full_n_o), 160'(0));
    cyc();
    #1;
    check("sw_switch_idle", 160'(o_write), 160'(0));
    check("sw_switch_ready", 160'(full_n_o), 160'(0));
    check("sw_switch_sel", 160'(cur_sel), 160'(0));
    cyc();
    din = 32'd24;
    #1;
    check("sw_new_sel", 160'(cur_sel), 160'(2));
    check("sw_new_ready", 160'(full_n_o), 160'(1));
    check("sw_new_idle", 160'(o_write), 160'(0));
    cyc();
    wr = 1'b0;
    #1;
    check("sw_new_write", 160'(o_write), 160'(4'b0100));
    check("sw_new_data", 160'(o_din), 160'(128'(32'd24) << 64));
    cyc();
    #1;
    check("sw_no_stale", 160'(o_write), 160'(0));
    cyc();

    // Out-of-range request on the five-channel instance
    sel5 = 3'd5; sel_load5 = 1'b1;
    cyc();
    sel_load5 = 1'b0;
    #1;
    check("bad_sel_err", 160'(sel_err5), 160'(1));
    check("bad_cur_sel", 160'(cur_sel5), 160'(0));
    check("bad_still_run", 160'(full_n5), 160'(1));
    check("bad_no_write", 160'(o_write5), 160'(0));
    check("bad_no_data", o_din5, 160'(0));
    check("bad_no_drop", 160'(drop5), 160'(0));
    cyc();
    #1;
    check("bad_err_pulse", 160'(sel_err5), 160'(0));

    // Request for the channel already active is a no-op
    sel = 2'd2; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0;
    #1;
    check("noop_err", 160'(sel_err), 160'(0));
    check("noop_run", 160'(full_n_o), 160'(1));

    // Busy request during DRAIN
    o_full_n = 4'hB; wr = 1'b1; din = 32'd31;
    cyc();
    wr = 1'b0; sel = 2'd1; sel_load = 1'b1;
    cyc();
    #1;
    check("busy_first_err", 160'(sel_err), 160'(0));
    sel = 2'd3; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0; o_full_n = 4'hF;
    #1;
    check("busy_err", 160'(sel_err), 160'(1));
    check("busy_cur_sel", 160'(cur_sel), 160'(2));
    check("busy_drain_write", 160'(o_write), 160'(4'b0100));
    check("busy_drain_data", 160'(o_din), 160'(128'(32'd31) << 64));
    cyc();
    #1;
    check("busy_err_pulse", 160'(sel_err), 160'(0));
    cyc();
    cyc();
    #1;
    check("busy_final_sel", 160'(cur_sel), 160'(1));

    // Discard mode
    en = 1'b0; wr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      din = 32'(k);
      #1;
      check("dc_ready", 160'(full_n_o), 160'(1));
      check("dc_no_write", 160'(o_write), 160'(0));
      cyc();
    end
    wr = 1'b0;
    #1;
    check("dc_count", 160'(drop), 160'(10));
    force u_dut.drop_cnt_reg = 32'hFFFF_FFFE;
    cyc();
    release u_dut.drop_cnt_reg;
    #1;
    check("dc_preload", 160'(drop), 160'(32'hFFFF_FFFE));
    wr = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    wr = 1'b0;
    #1;
    check("dc_saturate", 160'(drop), 160'(32'hFFFF_FFFF));

    // Reset in the middle of DRAIN (active channel is 1)
    en = 1'b1; o_full_n = 4'hD; wr = 1'b1; din = 32'd41;
    cyc();
    din = 32'd42;
    cyc();
    wr = 1'b0; sel = 2'd3; sel_load = 1'b1;
    cyc();
    sel_load = 1'b0;
    #1;
    check("rm_drain", 160'(full_n_o), 160'(0));
    rst = 1'b1;
    #1;
    check("rm_rst_ready", 160'(full_n_o), 160'(0));
    check("rm_rst_write", 160'(o_write), 160'(0));
    cyc();
    rst = 1'b0; o_full_n = 4'hF;
    #1;
    check("rm_cur_sel", 160'(cur_sel), 160'(0));
    check("rm_run", 160'(full_n_o), 160'(1));
    check("rm_empty", 160'(o_write), 160'(0));
    check("rm_drop_clr", 160'(drop), 160'(0));
    cyc();
    #1;
    check("rm_still_empty", 160'(o_write), 160'(0));
    wr = 1'b1; din = 32'd51;
    cyc();
    wr = 1'b0;
    #1;
    check("rm_fresh_write", 160'(o_write), 160'(4'b0001));
    check("rm_fresh_data", 160'(o_din), 160'(51));
    cyc();
    #1;
    check("rm_fresh_done", 160'(o_write), 160'(0));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
